// File: rtl/digit_serial_adder.sv
// ============================================================================
// Module   : digit_serial_adder
// Brief    : Digit-serial adder/subtractor. It computes DIGIT bits per clock
//            through a ripple slice and keeps the carry in a register
//            between slices. Valid/ready handshakes on input and output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int C_N     = WIDTH / DIGIT;
    localparam int C_CNT_W = (C_N > 1) ? $clog2(C_N) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_N - 1);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
            $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [C_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;
    logic               r_ovf;

    logic [DIGIT:0]     w_sum;
    logic               w_c_msb;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_last;

    assign w_sum   = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, r_carry};
    // Carry into the slice MSB, recovered from the MSB sum bit.
    assign w_c_msb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_sum[DIGIT-1];
    assign w_last  = (r_cnt == C_LAST);

    // Partial results fill from the MSB end, so the last digit completes the word.
    generate
        if (C_N == 1) begin : g_single
            assign w_res_next = w_sum[DIGIT-1:0];
        end else begin : g_multi
            logic [WIDTH-1:0] r_res;

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    r_res <= '0;
                end else if (r_state == C_ST_RUN) begin
                    r_res <= w_res_next;
                end
            end

            assign w_res_next = {w_sum[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= C_ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= sub ? ~B : B;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                        r_state <= C_ST_RUN;
                    end
                end
                C_ST_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_sum[DIGIT];
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_s     <= w_res_next;
                        r_cout  <= w_sum[DIGIT];
                        r_ovf   <= w_c_msb ^ w_sum[DIGIT];
                        r_state <= C_ST_DONE;
                    end
                end
                C_ST_DONE: begin
                    if (out_ready) begin
                        r_state <= C_ST_IDLE;
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == C_ST_IDLE);
    assign out_valid = (r_state == C_ST_DONE);
    assign S         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Parametrised multi-cycle adder/subtractor. Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using a DIGIT-bit ripple-carry slice and a registered carry between slices. Operands enter and results leave through valid/ready handshakes. It sits between operand registers and a consumer (ALU result mux or accumulator) wherever a full-width ripple adder is too large or too slow for one cycle.

Parameters:
WIDTH, 16, operand and result width in bits
DIGIT, 4, bits processed per cycle; WIDTH % DIGIT != 0 is an elaboration error; DIGIT == WIDTH gives single-cycle operation

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and mode valid
in_ready  output  1  block can accept operands
A  input  WIDTH  operand A
B  input  WIDTH  operand B
cin  input  1  carry-in; used only when sub=0
sub  input  1  0 = A+B+cin, 1 = A-B (cin ignored)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
S  output  WIDTH  result
cout  output  1  carry-out; for subtraction, 1 = no borrow (A >= B unsigned)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, S=0, cout=0, ovf=0. All internal registers (operand shift registers, carry, digit counter) are cleared.
- Reset mid-operation: asserting Reset_n low aborts the operation immediately. No result is produced.
- Let N = WIDTH/DIGIT.
- State IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch A; latch B, or ~B when sub=1; latch carry = sub ? 1 : cin; clear the counter; go to RUN.
- State RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: add the low DIGIT bits of the A and B registers plus the carry register.
  - Shift the sum digit into the MSB end of the result shift register. Shift the operand registers right by DIGIT. Update the carry register and increment the counter.
  - On the last digit (counter == N-1): capture cout = final carry and ovf = carry into MSB XOR carry out of MSB. Load S from the completed result. Go to DONE.
- State DONE:
  - out_valid=1, in_ready=0.
  - S, cout and ovf are held stable while out_ready=0.
  - On out_ready=1: go to IDLE.
- New operands are accepted no earlier than the cycle after the result handshake. There is no overlap.
- Latency: operands accepted at edge k produce out_valid=1 after edge k+N. Throughput is one result per N+2 cycles when out_ready is held high.
- In IDLE, S/cout/ovf keep the last completed result. Only out_valid qualifies them.
- in_valid while in_ready=0 is ignored. The input is not latched.
- Operand inputs may change freely after the accept edge.
- Arithmetic is modulo 2^WIDTH.
- ovf is defined for the effective operation: A + B + cin, or A + ~B + 1.

Test Plan:
- WIDTH=16, DIGIT=4: A=0x1234, B=0x4321, cin=0, sub=0 -> out_valid rises exactly 4 cycles after accept; S=0x5555, cout=0, ovf=0.
- A=0xFFFF, B=0x0001, cin=0, add -> S=0x0000, cout=1, ovf=0. A=0x7FFF, B=0x0000, cin=1 -> S=0x8000, cout=0, ovf=1.
- Subtract: A=0x0005, B=0x0007 -> S=0xFFFE, cout=0, ovf=0. A=0x8000, B=0x0001 -> S=0x7FFF, cout=1, ovf=1. Both with cin=1 applied, which must be ignored.
- Backpressure: hold out_ready=0 for 3 cycles in DONE and drive in_valid=1 with new operands -> S/cout/ovf stable, in_ready=0, new operands not taken. Release out_ready -> IDLE, in_ready=1.
- Reset mid-RUN: assert Reset_n low after 2 digit cycles -> out_valid=0, S=0, cout=0, ovf=0, in_ready=1 immediately (asynchronous). Next operation after release computes correctly.
- DIGIT=16 (N=1): A=0x00FF, B=0x0001 -> S=0x0100 with out_valid 1 cycle after accept. Back-to-back transactions with out_ready=1 give N+2 cycle spacing.
